// File: rtl/hough_pkg.sv
// Shared types and helpers for the Hough accumulator controller.
package hough_pkg;

  typedef enum logic [2:0] {IDLE, CLEAR, VOTE, DRAIN, SCAN, DONE} accum_state_t;

  function automatic int unsigned calc_depth(input int unsigned rhos, input int unsigned thetas);
    return rhos * thetas;
  endfunction

endpackage

// File: rtl/hough_accum_ctrl.sv
// Hough accumulator controller: clears the vote RAM, accumulates votes with a
// two-stage read-modify-write pipeline, then scans the RAM for peaks.
module hough_accum_ctrl
  import hough_pkg::*;
#(
  parameter int THETAS     = 180,
  parameter int RHOS       = 360,
  parameter int ACCUM_BITS = 8,
  parameter int ADDR_BITS  = 16
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic [ACCUM_BITS-1:0]           threshold,
  input  logic                            votes_done,
  input  logic                            vote_empty,
  output logic                            vote_rd_en,
  input  logic [ADDR_BITS-1:0]            vote_index,
  output logic [ADDR_BITS-1:0]            mem_rd_addr,
  input  logic [ACCUM_BITS-1:0]           mem_rd_data,
  output logic                            mem_wr_en,
  output logic [ADDR_BITS-1:0]            mem_wr_addr,
  output logic [ACCUM_BITS-1:0]           mem_wr_data,
  input  logic                            out_full,
  output logic                            out_wr_en,
  output logic [ADDR_BITS+ACCUM_BITS-1:0] out_dout,
  output logic                            busy,
  output logic                            frame_done
);

  localparam int unsigned DEPTH = calc_depth(RHOS, THETAS);
  localparam int CW = ADDR_BITS + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_C = CW'(DEPTH - 1);
  localparam logic [ACCUM_BITS-1:0] SAT_C = '1;

  accum_state_t state_q, state_d;
  logic [CW-1:0] addrCnt_q, addrCnt_d;
  logic [ACCUM_BITS-1:0] thr_q, thr_d;
  logic s1Valid_q, s1Valid_d;
  logic [ADDR_BITS-1:0] s1Idx_q, s1Idx_d;
  logic fwdHit_q, fwdHit_d;
  logic [ACCUM_BITS-1:0] fwdVal_q, fwdVal_d;
  logic scanValid_q, scanValid_d;
  logic [ADDR_BITS-1:0] scanAddr_q, scanAddr_d;

  logic votePop, voteOk, s1Wr, scanHit, scanStall;
  logic [ACCUM_BITS-1:0] oldVal, incVal;

  // Forwarded value replaces RAM data when the previous vote hit the same cell.
  always_comb begin
    votePop   = (state_q == VOTE) && !vote_empty;
    voteOk    = votePop && ({1'b0, vote_index} < DEPTH_C);
    s1Wr      = s1Valid_q && ((state_q == VOTE) || (state_q == DRAIN));
    oldVal    = fwdHit_q ? fwdVal_q : mem_rd_data;
    incVal    = (oldVal == SAT_C) ? oldVal : oldVal + ACCUM_BITS'(1);
    scanHit   = (state_q == SCAN) && scanValid_q && (mem_rd_data >= thr_q);
    scanStall = scanHit && out_full;
  end

  always_comb begin
    vote_rd_en  = votePop;
    mem_rd_addr = '0;
    if (state_q == VOTE) begin
      mem_rd_addr = vote_index;
    end else if (state_q == SCAN) begin
      mem_rd_addr = scanStall ? scanAddr_q : addrCnt_q[ADDR_BITS-1:0];
    end
    mem_wr_en   = (state_q == CLEAR) || s1Wr;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    if (state_q == CLEAR) begin
      mem_wr_addr = addrCnt_q[ADDR_BITS-1:0];
    end else if (s1Wr) begin
      mem_wr_addr = s1Idx_q;
      mem_wr_data = incVal;
    end
    out_wr_en  = scanHit && !out_full;
    out_dout   = scanHit ? {scanAddr_q, mem_rd_data} : '0;
    busy       = (state_q != IDLE);
    frame_done = (state_q == DONE);
  end

  // A stalled scan re-reads the held cell so its data is still present when out_full drops.
  always_comb begin
    state_d     = state_q;
    addrCnt_d   = addrCnt_q;
    thr_d       = thr_q;
    s1Valid_d   = 1'b0;
    s1Idx_d     = s1Idx_q;
    fwdHit_d    = 1'b0;
    fwdVal_d    = fwdVal_q;
    scanValid_d = 1'b0;
    scanAddr_d  = scanAddr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = CLEAR;
          thr_d     = threshold;
          addrCnt_d = '0;
        end
      end
      CLEAR: begin
        if (addrCnt_q == LAST_C) begin
          addrCnt_d = '0;
          state_d   = VOTE;
        end else begin
          addrCnt_d = addrCnt_q + CW'(1);
        end
      end
      VOTE: begin
        if (voteOk) begin
          s1Valid_d = 1'b1;
          s1Idx_d   = vote_index;
          fwdHit_d  = s1Wr && (s1Idx_q == vote_index);
          fwdVal_d  = incVal;
        end
        if (votes_done && vote_empty) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        addrCnt_d = '0;
        state_d   = SCAN;
      end
      SCAN: begin
        if (scanStall) begin
          scanValid_d = 1'b1;
        end else if (addrCnt_q != DEPTH_C) begin
          scanValid_d = 1'b1;
          scanAddr_d  = addrCnt_q[ADDR_BITS-1:0];
          addrCnt_d   = addrCnt_q + CW'(1);
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addrCnt_q   <= '0;
      thr_q       <= '0;
      s1Valid_q   <= 1'b0;
      s1Idx_q     <= '0;
      fwdHit_q    <= 1'b0;
      fwdVal_q    <= '0;
      scanValid_q <= 1'b0;
      scanAddr_q  <= '0;
    end else begin
      state_q     <= state_d;
      addrCnt_q   <= addrCnt_d;
      thr_q       <= thr_d;
      s1Valid_q   <= s1Valid_d;
      s1Idx_q     <= s1Idx_d;
      fwdHit_q    <= fwdHit_d;
      fwdVal_q    <= fwdVal_d;
      scanValid_q <= scanValid_d;
      scanAddr_q  <= scanAddr_d;
    end
  end

endmodule

// File: tb/tb_hough_accum_ctrl.sv
// Self-checking bench for hough_accum_ctrl: RAM, vote FIFO and peak FIFO models
// plus a counting reference model of the accumulator.
module tb_hough_accum_ctrl;

  localparam int DEPTH = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [3:0] threshold = '0;
  logic votesDone = 1'b0;
  logic voteEmpty = 1'b1;
  logic voteRdEn;
  logic [4:0] voteIndex = '0;
  logic [4:0] memRdAddr;
  logic [3:0] memRdData = '0;
  logic memWrEn;
  logic [4:0] memWrAddr;
  logic [3:0] memWrData;
  logic outFull = 1'b0;
  logic outWrEn;
  logic [8:0] outDout;
  logic busy, frameDone;

  logic pushReq = 1'b0;
  logic [4:0] pushVal = '0;

  logic [3:0] ram [32];
  int vfifo[$];
  logic [8:0] pushes[$];
  logic [8:0] wlog[$];
  int cyc = 0;
  int frameDoneCnt = 0;
  int badPush = 0;

  int votes_q[$];
  logic [8:0] exp_q[$];
  int nValid;
  int startCyc;
  int vectors = 0;
  int miscompares = 0;

  hough_accum_ctrl #(.THETAS(4), .RHOS(4), .ACCUM_BITS(4), .ADDR_BITS(5)) dut (
    .clock(clock), .reset(reset), .start(start), .threshold(threshold),
    .votes_done(votesDone), .vote_empty(voteEmpty), .vote_rd_en(voteRdEn),
    .vote_index(voteIndex), .mem_rd_addr(memRdAddr), .mem_rd_data(memRdData),
    .mem_wr_en(memWrEn), .mem_wr_addr(memWrAddr), .mem_wr_data(memWrData),
    .out_full(outFull), .out_wr_en(outWrEn), .out_dout(outDout),
    .busy(busy), .frame_done(frameDone)
  );

  always #5 clock = ~clock;

  // Environment: show-ahead vote FIFO, 1-cycle-read RAM (scrambled by reset), peak FIFO capture.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (pushReq) vfifo.push_back(int'(pushVal));
    if (voteRdEn && vfifo.size() > 0) void'(vfifo.pop_front());
    voteEmpty <= (vfifo.size() == 0);
    voteIndex <= (vfifo.size() > 0) ? 5'(vfifo[0]) : 5'd0;
    if (reset) begin
      for (int i = 0; i < 32; i++) ram[i] <= 4'($urandom);
    end else if (memWrEn) begin
      ram[memWrAddr] <= memWrData;
      wlog.push_back({memWrAddr, memWrData});
    end
    memRdData <= ram[memRdAddr];
    if (outWrEn) pushes.push_back(outDout);
    if (outWrEn && outFull) badPush <= badPush + 1;
    if (frameDone) frameDoneCnt <= frameDoneCnt + 1;
  end

  // Reference: saturating per-cell counts, then every cell at or above threshold in address order.
  function automatic void build_expected(input int thr);
    int cnt[DEPTH];
    for (int a = 0; a < DEPTH; a++) cnt[a] = 0;
    exp_q.delete();
    nValid = 0;
    foreach (votes_q[i]) begin
      if (votes_q[i] < DEPTH) begin
        nValid++;
        if (cnt[votes_q[i]] < 15) cnt[votes_q[i]]++;
      end
    end
    for (int a = 0; a < DEPTH; a++)
      if (cnt[a] >= thr) exp_q.push_back({5'(a), 4'(cnt[a])});
  endfunction

  task automatic wait_frame_done(input int mode, output bit to);
    to = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if (frameDone === 1'b1) begin
        to = 1'b0;
        break;
      end
      if (mode == 1) outFull = 1'($urandom_range(0, 1));
      else if (mode == 2) outFull = ((cyc - startCyc) < 40);
      @(negedge clock);
    end
    outFull = 1'b0;
    votesDone = 1'b0;
    @(negedge clock);
  endtask

  task automatic run_frame(input int thr, input int mode, input int maxGap, input bit pokeStart, output bit to);
    outFull = (mode == 2);
    threshold = 4'(thr);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    threshold = 4'($urandom);
    startCyc = cyc;
    foreach (votes_q[i]) begin
      pushReq = 1'b0;
      repeat ($urandom_range(0, maxGap)) @(negedge clock);
      pushReq = 1'b1;
      pushVal = 5'(votes_q[i]);
      @(negedge clock);
    end
    pushReq = 1'b0;
    if (pokeStart) begin
      start = 1'b1;
      threshold = 4'($urandom);
      @(negedge clock);
      start = 1'b0;
    end
    votesDone = 1'b1;
    wait_frame_done(mode, to);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    vectors++;
    if ({busy, frameDone, voteRdEn, memWrEn, outWrEn} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_strobes: got %b expected 00000", {busy, frameDone, voteRdEn, memWrEn, outWrEn});
    end
    vectors++;
    if ({memRdAddr, memWrAddr, memWrData, outDout} !== 23'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_buses: got rd=%0d wa=%0d wd=%0d dout=%0h expected all 0", memRdAddr, memWrAddr, memWrData, outDout);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_clear();
    bit to;
    int pb;
    pb = pushes.size();
    threshold = 4'd1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    threshold = 4'd0;
    for (int i = 0; i < DEPTH; i++) begin
      vectors++;
      if ({memWrEn, memWrAddr, memWrData} !== {1'b1, 5'(i), 4'd0}) begin
        miscompares++;
        $display("[TB] FAIL clear_write[%0d]: got en=%0b addr=%0d data=%0d expected en=1 addr=%0d data=0", i, memWrEn, memWrAddr, memWrData, i);
      end
      @(negedge clock);
    end
    vectors++;
    if ({busy, memWrEn, voteRdEn} !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL clear_to_vote: got busy/wr/rd=%b expected 100", {busy, memWrEn, voteRdEn});
    end
    pushReq = 1'b1;
    pushVal = 5'd9;
    @(negedge clock);
    pushReq = 1'b0;
    vectors++;
    if ({voteRdEn, memRdAddr} !== {1'b1, 5'd9}) begin
      miscompares++;
      $display("[TB] FAIL vote_stage0: got rd_en=%0b addr=%0d expected 1 9", voteRdEn, memRdAddr);
    end
    @(negedge clock);
    vectors++;
    if ({memWrEn, memWrAddr, memWrData} !== {1'b1, 5'd9, 4'd1}) begin
      miscompares++;
      $display("[TB] FAIL vote_stage1: got en=%0b addr=%0d data=%0d expected 1 9 1", memWrEn, memWrAddr, memWrData);
    end
    votesDone = 1'b1;
    wait_frame_done(0, to);
    vectors++;
    if (to !== 1'b0 || pushes.size() - pb !== 1) begin
      miscompares++;
      $display("[TB] FAIL clear_frame: got timeout=%0b pushes=%0d expected 0 1", to, pushes.size() - pb);
    end else begin
      vectors++;
      if (pushes[pb] !== {5'd9, 4'd1}) begin
        miscompares++;
        $display("[TB] FAIL clear_peak: got %0h expected %0h", pushes[pb], {5'd9, 4'd1});
      end
    end
  endtask

  task automatic test_forward();
    bit to;
    int pb, fb;
    votes_q = {5, 5, 5};
    build_expected(2);
    pb = pushes.size();
    fb = frameDoneCnt;
    run_frame(2, 0, 0, 1'b0, to);
    vectors++;
    if (to !== 1'b0 || frameDoneCnt - fb !== 1) begin
      miscompares++;
      $display("[TB] FAIL fwd_frame_done: got timeout=%0b pulses=%0d expected 0 1", to, frameDoneCnt - fb);
    end
    vectors++;
    if (pushes.size() - pb !== 1 || exp_q[0] !== {5'd5, 4'd3}) begin
      miscompares++;
      $display("[TB] FAIL fwd_count: got %0d pushes expected 1", pushes.size() - pb);
    end else begin
      vectors++;
      if (pushes[pb] !== exp_q[0]) begin
        miscompares++;
        $display("[TB] FAIL fwd_peak: got %0h expected %0h", pushes[pb], exp_q[0]);
      end
    end
  endtask

  task automatic test_saturate();
    bit to;
    int pb;
    votes_q.delete();
    for (int i = 0; i < 20; i++) votes_q.push_back(7);
    build_expected(15);
    pb = pushes.size();
    run_frame(15, 0, 0, 1'b0, to);
    vectors++;
    if (to !== 1'b0 || pushes.size() - pb !== 1) begin
      miscompares++;
      $display("[TB] FAIL sat_count: got timeout=%0b pushes=%0d expected 0 1", to, pushes.size() - pb);
    end else begin
      vectors++;
      if (pushes[pb] !== exp_q[0]) begin
        miscompares++;
        $display("[TB] FAIL sat_peak: got %0h expected %0h", pushes[pb], exp_q[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int pb, bb;
    votes_q = {1, 1, 2, 2, 3, 3};
    build_expected(2);
    pb = pushes.size();
    bb = badPush;
    run_frame(2, 2, 0, 1'b0, to);
    vectors++;
    if (to !== 1'b0 || pushes.size() - pb !== exp_q.size() || badPush !== bb) begin
      miscompares++;
      $display("[TB] FAIL bp_count: got timeout=%0b pushes=%0d full_pushes=%0d expected 0 %0d 0", to, pushes.size() - pb, badPush - bb, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && pb + i < pushes.size(); i++) begin
      vectors++;
      if (pushes[pb + i] !== exp_q[i]) begin
        miscompares++;
        $display("[TB] FAIL bp_peak[%0d]: got %0h expected %0h", i, pushes[pb + i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_scan();
    bit to;
    int pb, wb;
    pb = pushes.size();
    threshold = 4'd0;
    outFull = 1'b1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    votesDone = 1'b1;
    repeat (30) @(negedge clock);
    vectors++;
    if (busy !== 1'b1 || pushes.size() !== pb) begin
      miscompares++;
      $display("[TB] FAIL scan_stall: got busy=%0b pushes=%0d expected 1 0", busy, pushes.size() - pb);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({busy, outWrEn, frameDone} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL scan_reset: got busy/wr/done=%b expected 000", {busy, outWrEn, frameDone});
    end
    @(negedge clock);
    reset = 1'b0;
    outFull = 1'b0;
    votesDone = 1'b0;
    @(negedge clock);
    votes_q = {3, 3};
    build_expected(0);
    pb = pushes.size();
    wb = wlog.size();
    run_frame(0, 0, 1, 1'b0, to);
    vectors++;
    if (to !== 1'b0 || wlog.size() - wb !== DEPTH + nValid || pushes.size() - pb !== exp_q.size()) begin
      miscompares++;
      $display("[TB] FAIL reclear_frame: got timeout=%0b writes=%0d pushes=%0d expected 0 %0d %0d", to, wlog.size() - wb, pushes.size() - pb, DEPTH + nValid, exp_q.size());
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        vectors++;
        if (wlog[wb + i] !== {5'(i), 4'd0}) begin
          miscompares++;
          $display("[TB] FAIL reclear_write[%0d]: got %0h expected %0h", i, wlog[wb + i], {5'(i), 4'd0});
        end
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (pushes[pb + i] !== exp_q[i]) begin
          miscompares++;
          $display("[TB] FAIL reclear_peak[%0d]: got %0h expected %0h", i, pushes[pb + i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_discard();
    bit to;
    int pb, wb;
    votes_q = {16};
    build_expected(0);
    pb = pushes.size();
    wb = wlog.size();
    run_frame(0, 0, 0, 1'b0, to);
    vectors++;
    if (to !== 1'b0 || wlog.size() - wb !== DEPTH || vfifo.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL discard: got timeout=%0b writes=%0d fifo_left=%0d expected 0 %0d 0", to, wlog.size() - wb, vfifo.size(), DEPTH);
    end
    vectors++;
    if (pushes.size() - pb !== DEPTH) begin
      miscompares++;
      $display("[TB] FAIL thr0_count: got %0d pushes expected %0d", pushes.size() - pb, DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        vectors++;
        if (pushes[pb + i] !== exp_q[i]) begin
          miscompares++;
          $display("[TB] FAIL thr0_peak[%0d]: got %0h expected %0h", i, pushes[pb + i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    bit to;
    int pb, wb, fb, bb, thr, n;
    for (int f = 0; f < 8; f++) begin
      votes_q.delete();
      n = $urandom_range(0, 24);
      for (int i = 0; i < n; i++)
        votes_q.push_back(($urandom_range(0, 3) == 0) ? 6 : int'($urandom_range(0, 17)));
      thr = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 5));
      build_expected(thr);
      pb = pushes.size();
      wb = wlog.size();
      fb = frameDoneCnt;
      bb = badPush;
      run_frame(thr, 1, f % 3, f[0], to);
      vectors++;
      if (to !== 1'b0 || frameDoneCnt - fb !== 1 || badPush !== bb || wlog.size() - wb !== DEPTH + nValid) begin
        miscompares++;
        $display("[TB] FAIL rand_frame[%0d]: got timeout=%0b done=%0d full_pushes=%0d writes=%0d expected 0 1 0 %0d", f, to, frameDoneCnt - fb, badPush - bb, wlog.size() - wb, DEPTH + nValid);
      end
      vectors++;
      if (pushes.size() - pb !== exp_q.size()) begin
        miscompares++;
        $display("[TB] FAIL rand_count[%0d]: got %0d pushes expected %0d", f, pushes.size() - pb, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && pb + i < pushes.size(); i++) begin
        vectors++;
        if (pushes[pb + i] !== exp_q[i]) begin
          miscompares++;
          $display("[TB] FAIL rand_peak[%0d.%0d]: got %0h expected %0h", f, i, pushes[pb + i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_forward();
    test_saturate();
    test_backpressure();
    test_reset_scan();
    test_discard();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
